// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state, bit-position and decode constants for the command word sequencer
package pic_pkg;

   typedef enum logic [2:0] {
      WAIT_ICW1 = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } seq_state_t;

   // D4 marks ICW1 on an A0=0 write; D4:D3 then split OCW2 from OCW3
   localparam int CMD_D4     = 4;
   localparam int CMD_D3     = 3;

   localparam int ICW1_IC4   = 0;
   localparam int ICW1_SNGL  = 1;
   localparam int ICW1_LTIM  = 3;

   localparam int ICW4_UPM   = 0;
   localparam int ICW4_AEOI  = 1;
   localparam int ICW4_BUF_LO = 2;
   localparam int ICW4_SFNM  = 4;

   localparam int OCW2_R     = 7;
   localparam int OCW2_SL    = 6;
   localparam int OCW2_EOI   = 5;

   localparam int OCW3_ESMM  = 6;
   localparam int OCW3_SMM   = 5;
   localparam int OCW3_P     = 2;
   localparam int OCW3_RR    = 1;
   localparam int OCW3_RIS   = 0;

   localparam logic [1:0] OCW2_TAG = 2'b00;
   localparam logic [1:0] OCW3_TAG = 2'b01;

   function automatic logic is_icw1(input logic a0, input logic [7:0] data);
      return !a0 && data[CMD_D4];
   endfunction

endpackage

// File: rtl/write_strobe_detect.sv
// rtl/write_strobe_detect.sv - one-cycle accept per CPU write strobe
module write_strobe_detect (
   input  logic clock,
   input  logic reset_bar,
   input  logic write_bar,
   input  logic chip_select_bar,
   output logic accept
);

   logic strobe;
   logic strobe_q;

   assign strobe = ~write_bar & ~chip_select_bar;
   assign accept = strobe & ~strobe_q;

   // strobe_q resets high so a strobe held through reset release is not taken as new
   always_ff @(posedge clock) begin
      if (!reset_bar) strobe_q <= 1'b1;
      else            strobe_q <= strobe;
   end

endmodule

// File: rtl/command_word_sequencer.sv
// rtl/command_word_sequencer.sv - ICW1..ICW4 initialization sequencer and OCW1..OCW3 register file
module command_word_sequencer
   import pic_pkg::*;
(
   input  logic       clock,
   input  logic       reset_bar,
   input  logic       chip_select_bar,
   input  logic       write_bar,
   input  logic       A0,
   input  logic [7:0] internal_bus,
   output logic       init_done,
   output logic [4:0] vector_base,
   output logic       level_triggered,
   output logic       single_mode,
   output logic       icw4_needed,
   output logic [7:0] cascade_config,
   output logic       microprocessor_mode,
   output logic       auto_eoi,
   output logic       special_fully_nested,
   output logic [1:0] buffered_mode,
   output logic [7:0] interrupt_mask,
   output logic       ocw2_pulse,
   output logic       ocw2_rotate,
   output logic       ocw2_specific,
   output logic       ocw2_eoi,
   output logic [2:0] ocw2_level,
   output logic       read_isr_select,
   output logic       special_mask_mode,
   output logic       poll_pulse
);

   seq_state_t state, next_state;
   logic accept;
   logic do_icw1, do_icw2, do_icw3, do_icw4, do_ocw1, do_ocw2, do_ocw3;

   write_strobe_detect u_strobe (
      .clock           (clock),
      .reset_bar       (reset_bar),
      .write_bar       (write_bar),
      .chip_select_bar (chip_select_bar),
      .accept          (accept)
   );

   assign init_done = (state == READY);

   always_comb begin
      next_state = state;
      do_icw1 = 1'b0;
      do_icw2 = 1'b0;
      do_icw3 = 1'b0;
      do_icw4 = 1'b0;
      do_ocw1 = 1'b0;
      do_ocw2 = 1'b0;
      do_ocw3 = 1'b0;
      if (accept && is_icw1(A0, internal_bus)) begin
         do_icw1    = 1'b1;
         next_state = WAIT_ICW2;
      end else if (accept) begin
         case (state)
            WAIT_ICW2: if (A0) begin
               do_icw2 = 1'b1;
               if (!single_mode)     next_state = WAIT_ICW3;
               else if (icw4_needed) next_state = WAIT_ICW4;
               else                  next_state = READY;
            end
            WAIT_ICW3: if (A0) begin
               do_icw3    = 1'b1;
               next_state = icw4_needed ? WAIT_ICW4 : READY;
            end
            WAIT_ICW4: if (A0) begin
               do_icw4    = 1'b1;
               next_state = READY;
            end
            READY: begin
               if (A0)                                            do_ocw1 = 1'b1;
               else if (internal_bus[CMD_D4:CMD_D3] == OCW2_TAG)  do_ocw2 = 1'b1;
               else if (internal_bus[CMD_D4:CMD_D3] == OCW3_TAG)  do_ocw3 = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_bar) state <= WAIT_ICW1;
      else            state <= next_state;
   end

   always_ff @(posedge clock) begin
      if (!reset_bar) begin
         vector_base          <= '0;
         level_triggered      <= 1'b0;
         single_mode          <= 1'b0;
         icw4_needed          <= 1'b0;
         cascade_config       <= '0;
         microprocessor_mode  <= 1'b0;
         auto_eoi             <= 1'b0;
         special_fully_nested <= 1'b0;
         buffered_mode        <= '0;
         interrupt_mask       <= '0;
         ocw2_pulse           <= 1'b0;
         ocw2_rotate          <= 1'b0;
         ocw2_specific        <= 1'b0;
         ocw2_eoi             <= 1'b0;
         ocw2_level           <= '0;
         read_isr_select      <= 1'b0;
         special_mask_mode    <= 1'b0;
         poll_pulse           <= 1'b0;
      end else begin
         ocw2_pulse <= do_ocw2;
         poll_pulse <= do_ocw3 & internal_bus[OCW3_P];
         if (do_icw1) begin
            level_triggered   <= internal_bus[ICW1_LTIM];
            single_mode       <= internal_bus[ICW1_SNGL];
            icw4_needed       <= internal_bus[ICW1_IC4];
            interrupt_mask    <= '0;
            read_isr_select   <= 1'b0;
            special_mask_mode <= 1'b0;
            // No ICW4 will follow, so its fields must not keep stale values
            if (!internal_bus[ICW1_IC4]) begin
               microprocessor_mode  <= 1'b0;
               auto_eoi             <= 1'b0;
               special_fully_nested <= 1'b0;
               buffered_mode        <= '0;
            end
         end
         if (do_icw2) vector_base    <= internal_bus[7:3];
         if (do_icw3) cascade_config <= internal_bus;
         if (do_icw4) begin
            microprocessor_mode  <= internal_bus[ICW4_UPM];
            auto_eoi             <= internal_bus[ICW4_AEOI];
            special_fully_nested <= internal_bus[ICW4_SFNM];
            buffered_mode        <= internal_bus[ICW4_BUF_LO+1:ICW4_BUF_LO];
         end
         if (do_ocw1) interrupt_mask <= internal_bus;
         if (do_ocw2) begin
            ocw2_rotate   <= internal_bus[OCW2_R];
            ocw2_specific <= internal_bus[OCW2_SL];
            ocw2_eoi      <= internal_bus[OCW2_EOI];
            ocw2_level    <= internal_bus[2:0];
         end
         if (do_ocw3) begin
            if (internal_bus[OCW3_RR])   read_isr_select   <= internal_bus[OCW3_RIS];
            if (internal_bus[OCW3_ESMM]) special_mask_mode <= internal_bus[OCW3_SMM];
         end
      end
   end

endmodule

// File: tb/tb_command_word_sequencer.sv
// tb/tb_command_word_sequencer.sv - directed self-checking bench for command_word_sequencer
module tb_command_word_sequencer;

   logic       clock = 1'b0;
   logic       reset_bar = 1'b0;
   logic       chip_select_bar = 1'b1;
   logic       write_bar = 1'b1;
   logic       A0 = 1'b0;
   logic [7:0] internal_bus = 8'h00;
   logic       init_done;
   logic [4:0] vector_base;
   logic       level_triggered, single_mode, icw4_needed;
   logic [7:0] cascade_config;
   logic       microprocessor_mode, auto_eoi, special_fully_nested;
   logic [1:0] buffered_mode;
   logic [7:0] interrupt_mask;
   logic       ocw2_pulse, ocw2_rotate, ocw2_specific, ocw2_eoi;
   logic [2:0] ocw2_level;
   logic       read_isr_select, special_mask_mode, poll_pulse;

   int total = 0;
   int bad = 0;
   int ocw2_count = 0;
   int poll_count = 0;
   int both_count = 0;
   int last_ocw2 = 0;
   int last_poll = 0;

   command_word_sequencer dut (
      .clock                (clock),
      .reset_bar            (reset_bar),
      .chip_select_bar      (chip_select_bar),
      .write_bar            (write_bar),
      .A0                   (A0),
      .internal_bus         (internal_bus),
      .init_done            (init_done),
      .vector_base          (vector_base),
      .level_triggered      (level_triggered),
      .single_mode          (single_mode),
      .icw4_needed          (icw4_needed),
      .cascade_config       (cascade_config),
      .microprocessor_mode  (microprocessor_mode),
      .auto_eoi             (auto_eoi),
      .special_fully_nested (special_fully_nested),
      .buffered_mode        (buffered_mode),
      .interrupt_mask       (interrupt_mask),
      .ocw2_pulse           (ocw2_pulse),
      .ocw2_rotate          (ocw2_rotate),
      .ocw2_specific        (ocw2_specific),
      .ocw2_eoi             (ocw2_eoi),
      .ocw2_level           (ocw2_level),
      .read_isr_select      (read_isr_select),
      .special_mask_mode    (special_mask_mode),
      .poll_pulse           (poll_pulse)
   );

   always #5 clock = ~clock;

   logic [39:0] all_outputs;
   assign all_outputs = {init_done, vector_base, level_triggered, single_mode, icw4_needed,
                         cascade_config, microprocessor_mode, auto_eoi, special_fully_nested,
                         buffered_mode, interrupt_mask, ocw2_pulse, ocw2_rotate, ocw2_specific,
                         ocw2_eoi, ocw2_level, read_isr_select, special_mask_mode, poll_pulse};

   always @(negedge clock) begin
      if (ocw2_pulse) ocw2_count++;
      if (poll_pulse) poll_count++;
      if (ocw2_pulse && poll_pulse) both_count++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cpu_write(input logic a0, input logic [7:0] data, input int hold, input logic cs_bar);
      @(negedge clock);
      A0 = a0;
      internal_bus = data;
      chip_select_bar = cs_bar;
      write_bar = 1'b0;
      repeat (hold) @(negedge clock);
      write_bar = 1'b1;
      chip_select_bar = 1'b1;
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_bar = 1'b0;
      repeat (2) @(negedge clock);
      reset_bar = 1'b1;
   endtask

   task automatic mark_pulses();
      last_ocw2 = ocw2_count;
      last_poll = poll_count;
   endtask

   initial begin
      do_reset();
      @(negedge clock);
      check_eq("reset_outputs", all_outputs, 0);

      // single mode with ICW4
      cpu_write(1'b0, 8'h13, 1, 1'b0);
      cpu_write(1'b1, 8'h48, 1, 1'b0);
      check_eq("icw4_wait_init_done", init_done, 0);
      check_eq("single_mode", single_mode, 1);
      cpu_write(1'b1, 8'h03, 1, 1'b0);
      check_eq("init_done_1", init_done, 1);
      check_eq("vector_base_09", vector_base, 5'h09);
      check_eq("auto_eoi", auto_eoi, 1);
      check_eq("upm", microprocessor_mode, 1);

      // cascade sequence, with an A0=0 non-ICW1 write ignored in WAIT_ICW2
      cpu_write(1'b0, 8'h11, 1, 1'b0);
      cpu_write(1'b0, 8'h08, 1, 1'b0);
      cpu_write(1'b1, 8'h20, 1, 1'b0);
      check_eq("vector_base_04", vector_base, 5'h04);
      check_eq("icw3_wait", init_done, 0);
      cpu_write(1'b1, 8'h04, 1, 1'b0);
      cpu_write(1'b1, 8'h01, 1, 1'b0);
      check_eq("cascade_config", cascade_config, 8'h04);
      check_eq("init_done_2", init_done, 1);
      check_eq("aeoi_cleared", auto_eoi, 0);
      cpu_write(1'b1, 8'hA5, 1, 1'b0);
      check_eq("mask_A5", interrupt_mask, 8'hA5);

      // OCW2 / OCW3
      mark_pulses();
      cpu_write(1'b0, 8'h20, 1, 1'b0);
      check_eq("ocw2_pulse_once", ocw2_count - last_ocw2, 1);
      check_eq("ocw2_fields", {ocw2_rotate, ocw2_specific, ocw2_eoi, ocw2_level}, 6'b001000);
      cpu_write(1'b0, 8'h0B, 1, 1'b0);
      check_eq("ris_set", read_isr_select, 1);
      mark_pulses();
      cpu_write(1'b0, 8'h0C, 1, 1'b0);
      check_eq("poll_once", poll_count - last_poll, 1);
      check_eq("poll_no_ocw2", ocw2_count - last_ocw2, 0);
      check_eq("ris_kept", read_isr_select, 1);
      cpu_write(1'b0, 8'h68, 1, 1'b0);
      check_eq("smm_set", special_mask_mode, 1);

      // long strobe and deselected write
      mark_pulses();
      cpu_write(1'b0, 8'hE3, 10, 1'b0);
      check_eq("long_strobe_one_pulse", ocw2_count - last_ocw2, 1);
      check_eq("ocw2_fields_E3", {ocw2_rotate, ocw2_specific, ocw2_eoi, ocw2_level}, 6'b111011);
      cpu_write(1'b1, 8'h00, 1, 1'b1);
      check_eq("cs_high_ignored", interrupt_mask, 8'hA5);

      // ICW1 while READY, no ICW4 forces ICW4 fields to zero
      cpu_write(1'b0, 8'h12, 1, 1'b0);
      check_eq("icw1_ready_mask", interrupt_mask, 8'h00);
      check_eq("icw1_ready_init_done", init_done, 0);
      check_eq("icw1_clears_ris_smm", {read_isr_select, special_mask_mode}, 2'b00);
      check_eq("icw4_forced_zero", microprocessor_mode, 0);
      cpu_write(1'b1, 8'h08, 1, 1'b0);
      check_eq("no_icw4_ready", {init_done, vector_base}, {1'b1, 5'h01});

      // reset inside WAIT_ICW3
      cpu_write(1'b0, 8'h10, 1, 1'b0);
      cpu_write(1'b1, 8'h30, 1, 1'b0);
      check_eq("wait_icw3_vb", vector_base, 5'h06);
      do_reset();
      @(negedge clock);
      check_eq("mid_reset_outputs", all_outputs, 0);
      cpu_write(1'b1, 8'hFF, 1, 1'b0);
      check_eq("a0_ignored_wait_icw1", all_outputs, 0);
      cpu_write(1'b0, 8'h1A, 1, 1'b0);
      cpu_write(1'b1, 8'hF8, 1, 1'b0);
      check_eq("reinit_ready", {init_done, vector_base, level_triggered, single_mode}, {1'b1, 5'h1F, 1'b1, 1'b1});

      // strobe held across reset release
      @(negedge clock);
      reset_bar = 1'b0;
      A0 = 1'b0;
      internal_bus = 8'h18;
      chip_select_bar = 1'b0;
      write_bar = 1'b0;
      repeat (2) @(negedge clock);
      reset_bar = 1'b1;
      repeat (3) @(negedge clock);
      write_bar = 1'b1;
      chip_select_bar = 1'b1;
      @(negedge clock);
      check_eq("held_strobe_no_accept", all_outputs, 0);

      check_eq("pulses_never_overlap", both_count, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/command_word_sequencer.md
COMMAND_WORD_SEQUENCER -- requirements
Module: command_word_sequencer

Interface
REQ-001 clock  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset_bar  input  1  reset, synchronous, active-low.
REQ-003 chip_select_bar  input  1  chip select, active-low.
REQ-004 write_bar  input  1  CPU write strobe, active-low.
REQ-005 A0  input  1  command-word address bit.
REQ-006 internal_bus  input  8  write data driven by the read/write logic.
REQ-007 init_done  output  1  ICW sequence complete, OCWs accepted.
REQ-008 vector_base  output  5  ICW2[7:3], interrupt vector T7..T3.
REQ-009 level_triggered, single_mode, icw4_needed  output  1 each  ICW1 bits 3, 1, 0.
REQ-010 cascade_config  output  8  ICW3 byte.
REQ-011 microprocessor_mode, auto_eoi, special_fully_nested  output  1 each  ICW4 bits 0, 1, 4.
REQ-012 buffered_mode  output  2  ICW4[3:2].
REQ-013 interrupt_mask  output  8  OCW1 IMR.
REQ-014 ocw2_pulse  output  1  one-cycle strobe on accepted OCW2.
REQ-015 ocw2_rotate, ocw2_specific, ocw2_eoi, ocw2_level[2:0]  output  1/1/1/3  last OCW2 fields (bits 7, 6, 5, 2:0).
REQ-016 read_isr_select  output  1  0 = IRR, 1 = ISR on status read.
REQ-017 special_mask_mode  output  1  OCW3 SMM state.
REQ-018 poll_pulse  output  1  one-cycle strobe on OCW3 with P=1.

Function
REQ-019 Write strobe = ~write_bar & ~chip_select_bar; registered copy strobe_q; accepted write = strobe & ~strobe_q; exactly one accept per CPU write however long the strobe.
REQ-020 On an accepted write, internal_bus and A0 are sampled at that clock edge; outputs reflect the write on the following cycle.
REQ-021 States: WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-022 ICW1 (A0=0, D4=1) is accepted in any state: latches ICW1 bits, clears interrupt_mask, read_isr_select, special_mask_mode, init_done; next WAIT_ICW2.
REQ-023 WAIT_ICW2, A0=1: latch vector_base; next WAIT_ICW3 if single_mode=0, else WAIT_ICW4 if icw4_needed=1, else READY.
REQ-024 WAIT_ICW3, A0=1: latch cascade_config; next WAIT_ICW4 if icw4_needed=1, else READY.
REQ-025 WAIT_ICW4, A0=1: latch ICW4 bits; next READY.
REQ-026 When icw4_needed=0, ICW4 fields are forced to 0 on ICW1 acceptance.
REQ-027 init_done = 1 exactly while state is READY.
REQ-028 WAIT_ICW2..4, A0=0 with D4=0: write ignored, state and registers unchanged.
REQ-029 WAIT_ICW1, any non-ICW1 write: ignored.
REQ-030 READY, A0=1: OCW1, interrupt_mask <= internal_bus.
REQ-031 READY, A0=0, D4=0, D3=0: OCW2; latch fields, ocw2_pulse high one cycle.
REQ-032 READY, A0=0, D4=0, D3=1: OCW3; RR=1 sets read_isr_select<=RIS; ESMM=1 sets special_mask_mode<=SMM; P=1 gives poll_pulse one cycle; cleared bits leave state unchanged.
REQ-033 ocw2_pulse and poll_pulse are never high in the same cycle, nor for two consecutive cycles from one write.
REQ-034 Strobe held across reset deassertion does not produce an accept.

Reset
REQ-035 reset_bar=0 at a clock edge: state WAIT_ICW1, strobe_q=1, every output 0.
REQ-036 Reset mid-sequence discards partial initialization; a fresh ICW1 is required.

Structure
REQ-037 Shared package pic_pkg holds the state enum, ICW/OCW bit-position constants, and the OCW2/OCW3 decode constants.
REQ-038 One sub-module write_strobe_detect produces the single-cycle accept from write_bar/chip_select_bar.

Verification
REQ-039 Reset, ICW1=0x13, ICW2=0x48 -> single mode, ICW4 wait; ICW4=0x03 -> init_done=1, vector_base=0x09, auto_eoi=1, microprocessor_mode=1.
REQ-040 ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x01 -> cascade_config=0x04; OCW1=0xA5 -> interrupt_mask=0xA5.
REQ-041 READY, OCW2=0x20 -> one-cycle ocw2_pulse, ocw2_eoi=1, level 0; OCW3=0x0B -> read_isr_select=1; OCW3=0x0C -> poll_pulse one cycle only.
REQ-042 write_bar held low 10 cycles with OCW2 -> exactly one ocw2_pulse; chip_select_bar=1 write -> no change.
REQ-043 Reset during WAIT_ICW3 -> all outputs 0, A0=1 write ignored until ICW1; ICW1 in READY -> mask 0, init_done=0.
